// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide unit.
// Operation encodings match the control unit's muldiv_op field.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;
  localparam int MULDIV_ITERS = 32;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } ctrl_state_t;

  // Two's-complement magnitude; 0x8000_0000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [MULDIV_WIDTH-1:0] abs_w(input logic [MULDIV_WIDTH-1:0] v);
    return v[MULDIV_WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_engine.sv
// Radix-2 iterative datapath: shift-add multiply or restoring divide on
// unsigned magnitudes. One step per enabled cycle; start loads operands.
module muldiv_engine #(
  parameter int WIDTH = 32
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               start,
  input  logic               en,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  logic [WIDTH-1:0] acc;    // product high half
  logic [WIDTH-1:0] shreg;  // multiplier -> product low half, or dividend -> quotient
  logic [WIDTH-1:0] rem;    // partial remainder
  logic [WIDTH-1:0] bop;    // multiplicand / divisor

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    mul_sum = {1'b0, acc} + (shreg[0] ? {1'b0, bop} : '0);
    shifted = {rem, shreg[WIDTH-1]};
    ge      = (shifted >= {1'b0, bop});
    // rem < bop always holds, so a successful subtract fits in WIDTH bits.
    diff    = shifted[WIDTH-1:0] - bop;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      shreg <= '0;
      rem   <= '0;
      bop   <= '0;
    end else if (start) begin
      acc   <= '0;
      shreg <= a;
      rem   <= '0;
      bop   <= b;
    end else if (en) begin
      if (is_div) begin
        rem   <= ge ? diff : shifted[WIDTH-1:0];
        shreg <= {shreg[WIDTH-2:0], ge};
      end else begin
        acc   <= mul_sum[WIDTH:1];
        shreg <= {mul_sum[0], shreg[WIDTH-1:1]};
      end
    end
  end

  assign product   = {acc, shreg};
  assign quotient  = shreg;
  assign remainder = rem;

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// MULT/DIV sequencer and HI/LO owner; stalls MFHI/MFLO while busy.
// Handshake: op_valid is sampled only when op_ready (IDLE) and abort is low.
module muldiv_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             op_valid,
  input  muldiv_op_t       op,
  output logic             op_ready,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             abort,
  input  logic             mf_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output ctrl_state_t      state_dbg
);

  localparam int CW = $clog2(ITERS);

  ctrl_state_t state, state_n;
  logic [CW-1:0]      count;
  logic               is_arith, is_signed, is_div_op, accept;
  logic               is_div_q, neg_res_q, neg_rem_q, div_zero_q;
  logic [WIDTH-1:0]   rs_raw_q, eng_a, eng_b;
  logic [2*WIDTH-1:0] product, prod_fix;
  logic [WIDTH-1:0]   quotient, remainder, hi_res, lo_res;

  always_comb begin
    is_arith  = (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    is_signed = (op == MULT) || (op == DIV);
    is_div_op = (op == DIV) || (op == DIVU);
    accept    = (state == IDLE) && op_valid && !abort && is_arith;
    eng_a     = is_signed ? abs_w(rs_val) : rs_val;
    eng_b     = is_signed ? abs_w(rt_val) : rt_val;
  end

  muldiv_engine #(.WIDTH(WIDTH)) u_engine (
    .Clk       (Clk),
    .reset     (reset),
    .start     (accept),
    .en        (state == ITER),
    .is_div    (is_div_q),
    .a         (eng_a),
    .b         (eng_b),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = ITER;
      ITER:    if (abort) state_n = IDLE;
               else if (count == CW'(ITERS - 1)) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    op_ready  = (state == IDLE);
    busy      = (state != IDLE);
    stall     = mf_req && busy;
    state_dbg = state;
    prod_fix  = neg_res_q ? -product : product;
    hi_res    = prod_fix[2*WIDTH-1:WIDTH];
    lo_res    = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      // Divide-by-zero leaves the raw dividend in HI, no trap.
      if (div_zero_q) begin
        lo_res = '1;
        hi_res = rs_raw_q;
      end else begin
        lo_res = neg_res_q ? -quotient : quotient;
        hi_res = neg_rem_q ? -remainder : remainder;
      end
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      hi         <= '0;
      lo         <= '0;
      done       <= 1'b0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      rs_raw_q   <= '0;
    end else begin
      state <= state_n;
      done  <= (state == FIX) && !abort;
      if (accept) begin
        count      <= '0;
        is_div_q   <= is_div_op;
        neg_res_q  <= is_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
        neg_rem_q  <= is_signed && rs_val[WIDTH-1];
        div_zero_q <= (rt_val == '0);
        rs_raw_q   <= rs_val;
      end else if (state == ITER) begin
        count <= count + 1'b1;
      end
      if ((state == IDLE) && op_valid && !abort) begin
        if (op == MTHI) hi <= rs_val;
        if (op == MTLO) lo <= rs_val;
      end
      if ((state == FIX) && !abort) begin
        hi <= hi_res;
        lo <= lo_res;
      end
    end
  end

endmodule

// File: doc/muldiv_hilo_ctrl.md
Name: muldiv_hilo_ctrl

Overview:
Sequencer and owner of the HI/LO register pair for the MIPS core's MULT/MULTU/DIV/DIVU/MTHI/MTLO instructions. It accepts one operation from the control unit and drives a 32-iteration radix-2 engine: shift-add multiply or restoring divide. It applies sign correction and commits the result to HI/LO. It also produces the busy/stall interlock that freezes the pipeline when MFHI/MFLO is decoded while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI/LO each WIDTH bits.
- ITERS, WIDTH, number of engine iterations.

Ports:
- Clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- op_valid  in  1  control unit presents an op this cycle
- op  in  3  muldiv_op_t: NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO
- op_ready  out  1  op accepted this cycle (= state==IDLE)
- rs_val  in  WIDTH  lhs / dividend / MTxx source
- rt_val  in  WIDTH  rhs / divisor
- abort  in  1  synchronous cancel of in-flight op (exception flush)
- mf_req  in  1  MFHI or MFLO decoded in ID
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  state != IDLE
- stall  out  1  mf_req & busy (combinational)
- done  out  1  one-cycle pulse after HI/LO commit of MULT/DIV

Behaviour:
- Reset (async): state=IDLE; hi=0, lo=0, done=0, iteration counter=0, engine registers=0.
- FSM states:
  - IDLE: op_ready=1.
    - op_valid with MULT/MULTU/DIV/DIVU: latch |rs|, |rt| (signed ops) or raw (unsigned ops), plus the sign flags; go to ITER with count=0.
    - op_valid with MTHI/MTLO: write hi/lo from rs_val at that edge; stay IDLE; no busy, no done.
    - NOP or op_valid=0: hold.
  - ITER: one engine step per cycle; count increments; after ITERS steps (count==ITERS-1 at the edge) go to FIX.
  - FIX: apply sign correction, write hi/lo, set done for next cycle, go to IDLE.
- Latency: op accepted at edge E0; busy high from E0 to E(ITERS+1); hi/lo written at E(ITERS+1) = E33; done high for one cycle after E33; busy low in that same cycle. Back-to-back ops are therefore accepted at most every 34 cycles.
- op_valid while busy: ignored (op_ready=0). The control unit must hold the op, which it does via stall.
- Multiply: 2·WIDTH product, with {hi,lo}=product. Signed: negate the 64-bit product if the operand signs differ.
- Divide: lo=quotient, hi=remainder.
  - Signed: the quotient is negated if the signs differ; the remainder takes the sign of the dividend.
  - Divisor zero (signed or unsigned): lo=32'hFFFF_FFFF, hi=rs_val as issued; no trap.
  - 0x8000_0000 / 0xFFFF_FFFF (signed): lo=0x8000_0000, hi=0.
- abort:
  - In ITER or FIX: return to IDLE next edge; hi/lo keep the values they held before the op; no done.
  - In IDLE: no effect; abort has priority over op_valid in the same cycle.
- reset mid-operation: immediate IDLE, hi=lo=0.
- hi/lo are never partially updated; both are written in the same edge.

Decomposition:
- Package muldiv_pkg:
  - muldiv_op_t enum (3 bits).
  - ctrl_state_t {IDLE, ITER, FIX}.
  - Constant MULDIV_ITERS=32.
  - Function abs_w.
- Sub-module muldiv_engine: the iterative datapath only.
  - Inputs: start, is_div, a, b.
  - Registers: accumulator, shifting operand, partial remainder.
  - One step per enable cycle.
  - Outputs: raw 64-bit product, or quotient/remainder.
- The controller owns the FSM, counter, sign fix-up, HI/LO and the interlock.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy for 33 cycles; then hi=0xFFFFFFFE, lo=0x00000001, done pulse exactly 1 cycle.
- MULT rs=-3 rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV rs=-7 rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=5 rt=0 -> lo=0xFFFFFFFF, hi=0x00000005. Then DIV rs=0x80000000 rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x1234 in IDLE -> hi=0x1234 next edge, busy stays 0. mf_req during MULT ITER -> stall=1 each cycle until busy drops. MTLO during busy -> op_ready=0 and lo unchanged.
- Preload hi=0xAA, lo=0xBB; issue MULT; abort at cycle 20 -> IDLE next edge, hi=0xAA, lo=0xBB, no done.
- Issue DIVU; assert reset at cycle 10 -> busy=0, hi=lo=0 immediately. After release, MULTU 6*7 -> lo=42, hi=0.
